// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer / full-flag controller of the dual-clock FIFO (write clock domain).
// Optional almost-full comparator is enabled by defining FIFO_ALMOST_FULL_EN.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH:0]   i_rd_ptr_sync,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [ADDR_WIDTH:0]   o_wr_ptr,
  output logic                  o_full,
  output logic [ADDR_WIDTH:0]   o_wr_level,
  output logic                  o_overflow,
  output logic                  o_almost_full
);
  localparam int PW = ADDR_WIDTH + 1;

  if (ADDR_WIDTH < 2 || AF_THRESH < 1 || AF_THRESH > (1 << ADDR_WIDTH)) begin : g_bad_param
    $error("fifo_wr_ctrl: ADDR_WIDTH must be >=2 and AF_THRESH within 1..depth");
  end

  logic [PW-1:0] wr_bin, wr_bin_next, wr_gray_next;
  logic [PW-1:0] rd_bin, full_cmp, level_next;
  logic          accept;

  assign accept       = i_wr_en & ~o_full;
  assign o_mem_we     = accept;
  assign o_wr_addr    = wr_bin[ADDR_WIDTH-1:0];
  assign wr_bin_next  = wr_bin + {{ADDR_WIDTH{1'b0}}, accept};
  assign wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);

  // Gray->binary: each bit is the XOR of all Gray bits at and above it.
  for (genvar i = 0; i < PW; i++) begin : g_g2b
    assign rd_bin[i] = ^i_rd_ptr_sync[PW-1:i];
  end

  // Full when write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  assign full_cmp   = {~i_rd_ptr_sync[ADDR_WIDTH:ADDR_WIDTH-1], i_rd_ptr_sync[ADDR_WIDTH-2:0]};
  assign level_next = wr_bin_next - rd_bin;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bin     <= '0;
      o_wr_ptr   <= '0;
      o_full     <= 1'b0;
      o_wr_level <= '0;
      o_overflow <= 1'b0;
    end else begin
      wr_bin     <= wr_bin_next;
      o_wr_ptr   <= wr_gray_next;
      o_full     <= (wr_gray_next == full_cmp);
      o_wr_level <= level_next;
      o_overflow <= i_wr_en & o_full;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) o_almost_full <= 1'b0;
    else          o_almost_full <= (level_next >= AF_T);
  end
`else
  assign o_almost_full = 1'b0;
`endif

endmodule
